// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a first-word fall-through byte FIFO.
// Received bytes leave on a valid/ready stream. Dropped bytes and bad stop bits
// raise sticky flags, which the consumer clears with clr_err.
module uart_rx_fifo #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     rxd,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_err,
    input  logic                     clr_err
);

    localparam int BIT_CYC  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int TW       = $clog2(BIT_CYC);
    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = PW + 1;

    localparam logic [TW-1:0] TMR_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TMR_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMR_HALF = TW'(HALF_CYC);
    localparam logic [TW-1:0] TMR_LAST = TW'(BIT_CYC - 1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Line synchronizer; rx_sync_r is the only view of the line the receiver uses.
    logic meta_r;
    logic rx_sync_r;

    // Receiver state.
    state_t         state_r,   state_s;
    logic [TW-1:0]  timer_r,   timer_s;
    logic [2:0]     bit_idx_r, bit_idx_s;
    logic [7:0]     shift_r,   shift_s;
    logic           push_s;
    logic           ferr_evt_s;

    // FIFO state.
    logic [7:0]     mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  rd_next_s;
    logic [CW-1:0]  count_r,   count_s;
    logic [7:0]     m_data_r,  head_s;
    logic           m_valid_r;
    logic           overflow_r, overflow_s;
    logic           frame_err_r, frame_err_s;
    logic           pop_s;
    logic           full_s;
    logic           push_acc_s;
    logic           drop_s;

    assign m_data     = m_data_r;
    assign m_valid    = m_valid_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;
    assign frame_err  = frame_err_r;

    // Two-flop synchronizer, preset to the idle (high) line level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_r    <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            meta_r    <= rxd;
            rx_sync_r <= meta_r;
        end
    end

    // Receiver state registers; reset drops any partially received byte.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= ST_IDLE;
            timer_r   <= TMR_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

    // Receiver next state: verify the start bit at mid-bit, then sample one bit per bit time.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        push_s     = 1'b0;
        ferr_evt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_sync_r) begin
                    state_s = ST_START;
                    timer_s = TMR_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_r == TMR_HALF) begin
                    timer_s = TMR_ZERO;
                    if (!rx_sync_r) begin
                        state_s   = ST_DATA;
                        bit_idx_s = 3'd0;
                    end else begin
                        // A low pulse shorter than half a bit is a glitch, not a start bit.
                        state_s = ST_IDLE;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_DATA: begin
                if (timer_r == TMR_LAST) begin
                    timer_s = TMR_ZERO;
                    shift_s = {rx_sync_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_STOP: begin
                if (timer_r == TMR_LAST) begin
                    timer_s = TMR_ZERO;
                    if (rx_sync_r) begin
                        push_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        ferr_evt_s = 1'b1;
                        state_s    = ST_BREAK;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_BREAK: begin
                // A line held low must return high before a new start bit is accepted.
                if (rx_sync_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = TMR_ZERO;
            end
        endcase
    end

    // FIFO control: a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    always_comb begin
        pop_s      = m_valid_r & m_ready;
        full_s     = (count_r == CNT_FULL);
        push_acc_s = push_s & (~full_s | pop_s);
        drop_s     = push_s & full_s & ~pop_s;
        rd_next_s  = rd_ptr_r + PTR_ONE;
        case ({push_acc_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
        // Next head byte: the registered output tracks the entry at the read pointer.
        if (pop_s) begin
            if (push_acc_s && (count_r == CNT_ONE)) begin
                head_s = shift_r;
            end else begin
                head_s = mem_r[rd_next_s];
            end
        end else if (push_acc_s && (count_r == CNT_ZERO)) begin
            head_s = shift_r;
        end else begin
            head_s = m_data_r;
        end
        // Sticky flags: a new event takes priority over a clear in the same cycle.
        if (drop_s) begin
            overflow_s = 1'b1;
        end else if (clr_err) begin
            overflow_s = 1'b0;
        end else begin
            overflow_s = overflow_r;
        end
        if (ferr_evt_s) begin
            frame_err_s = 1'b1;
        end else if (clr_err) begin
            frame_err_s = 1'b0;
        end else begin
            frame_err_s = frame_err_r;
        end
    end

    // FIFO storage; contents need no reset because the pointers and count qualify them.
    always_ff @(posedge sys_clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, count, registered head and sticky flags.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            m_data_r    <= 8'h00;
            m_valid_r   <= 1'b0;
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r     <= count_s;
            m_data_r    <= head_s;
            m_valid_r   <= (count_s != CNT_ZERO);
            overflow_r  <= overflow_s;
            frame_err_r <= frame_err_s;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo, run at a reduced bit time of 16 clocks.
module tb_uart_rx_fifo;

    // CLK_HZ=1600000, BAUD=100000 -> bit time (1600000+50000)/100000 = 16, half-bit 8.
    localparam int BIT_CYC = 16;
    localparam int HALF    = 8;
    localparam int DEPTH   = 16;
    localparam int FRAME   = 10 * BIT_CYC;
    // Stop-bit sample edge, counted from the edge before the start bit is driven:
    // 2 synchronizer edges + 1 IDLE edge + HALF+1 START edges + 9 bit times.
    localparam int STOP_EDGE = 3 + (HALF + 1) + 9 * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       m_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       frame_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .DEPTH(DEPTH)) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .rxd        (rxd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // strobe: 0 none, 1 m_ready high over the stop-sample edge, 2 clr_err high over it.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int strobe);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            rxd = bits[c / BIT_CYC];
            if (strobe == 1) m_ready = (c == STOP_EDGE - 1);
            if (strobe == 2) clr_err = (c == STOP_EDGE - 1);
            tick(1);
        end
        rxd = 1'b1;
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] bits;
        logic [7:0] d;
        logic [7:0] q[$];
        logic       ovf_m;
        logic       pop;
        int         sz;
        int         thr;

        // ---- reset values ----
        tick(3);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 8'h00);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        rst_n = 1'b1;
        tick(2);

        // ---- 1: reset mid-DATA of 0xA5 ----
        bits = {1'b1, 8'hA5, 1'b0};
        for (int c = 0; c < 60; c++) begin
            rxd = bits[c / BIT_CYC];
            tick(1);
        end
        rst_n = 1'b0;
        rxd   = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("t1_valid", m_valid, 0);
        chk("t1_count", fifo_count, 0);
        tick(3 * BIT_CYC);
        chk("t1_count_idle", fifo_count, 0);
        send_frame(8'h3C, 1'b1, 0);
        chk("t1_data", m_data, 8'h3C);
        chk("t1_count1", fifo_count, 1);
        pop_one();
        chk("t1_count0", fifo_count, 0);

        // ---- 2: 0x55 with m_ready low, exact push latency ----
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                chk("t2_valid_before", m_valid, 0);
                @(posedge clk);
                #1;
                chk("t2_valid_after", m_valid, 1);
                chk("t2_data", m_data, 8'h55);
            end
        join
        tick(5);
        chk("t2_hold_data", m_data, 8'h55);
        chk("t2_hold_valid", m_valid, 1);
        pop_one();
        chk("t2_count0", fifo_count, 0);
        chk("t2_valid0", m_valid, 0);

        // ---- 3: short low glitch ----
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(2 * BIT_CYC);
        chk("t3_count", fifo_count, 0);
        chk("t3_ferr", frame_err, 0);
        send_frame(8'hC3, 1'b1, 0);
        chk("t3_next", m_data, 8'hC3);
        pop_one();

        // ---- 4: bad stop bit plus break ----
        send_frame(8'h81, 1'b0, 0);
        rxd = 1'b0;
        tick(3 * BIT_CYC);
        rxd = 1'b1;
        tick(BIT_CYC);
        chk("t4_ferr", frame_err, 1);
        chk("t4_count", fifo_count, 0);
        tick(2 * BIT_CYC);
        chk("t4_count_idle", fifo_count, 0);
        send_frame(8'h7E, 1'b1, 0);
        chk("t4_data", m_data, 8'h7E);
        chk("t4_count1", fifo_count, 1);
        chk("t4_ferr_sticky", frame_err, 1);
        pop_one();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t4_ferr_clr", frame_err, 0);

        // ---- 5: overflow, then full push with simultaneous pop ----
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 0);
        chk("t5_count16", fifo_count, 16);
        chk("t5_ovf0", overflow, 0);
        send_frame(8'h10, 1'b1, 2);
        chk("t5_count_full", fifo_count, 16);
        chk("t5_ovf_wins_clr", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t5_drain", m_data, i);
            pop_one();
        end
        chk("t5_empty", fifo_count, 0);
        chk("t5_empty_valid", m_valid, 0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t5_ovf_clr", overflow, 0);
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 0);
        send_frame(8'h10, 1'b1, 1);
        chk("t5b_count", fifo_count, 16);
        chk("t5b_ovf", overflow, 0);
        for (int i = 1; i <= 16; i++) begin
            chk("t5b_drain", m_data, i);
            pop_one();
        end
        chk("t5b_empty", fifo_count, 0);

        // ---- 6: 64 back-to-back random bytes, random m_ready, scoreboard ----
        ovf_m = 1'b0;
        for (int b = 0; b < 64; b++) begin
            d    = 8'($urandom_range(0, 255));
            bits = {1'b1, d, 1'b0};
            thr  = (b < 32) ? 1 : 6;
            for (int c = 0; c < FRAME; c++) begin
                rxd     = bits[c / BIT_CYC];
                m_ready = ($urandom_range(0, 255) < thr);
                if (q.size() > 0) chk("t6_data", m_data, q[0]);
                sz  = q.size();
                pop = m_ready && (sz > 0);
                tick(1);
                if (pop) void'(q.pop_front());
                if (c == STOP_EDGE - 1) begin
                    if (sz < DEPTH || pop) q.push_back(d);
                    else ovf_m = 1'b1;
                end
                chk("t6_count", fifo_count, q.size());
            end
        end
        m_ready = 1'b0;
        rxd     = 1'b1;
        chk("t6_ovf", overflow, ovf_m);
        for (int i = 0; i < DEPTH && q.size() > 0; i++) begin
            chk("t6_drain", m_data, q[0]);
            pop_one();
            void'(q.pop_front());
        end
        chk("t6_final_count", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
